// File: rtl/apb_wait_slave_if.sv
// APB bus bundle between the master and apb_wait_slave.
// Clock and reset stay outside the bundle as plain ports.
interface apb_wait_slave_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_wait_slave.sv
// APB completer: byte-wide register file with programmable read/write wait
// states, pslverr on illegal accesses, and a read-only write counter at 8'hFF.
module apb_wait_slave #(
  parameter int DEPTH   = 64,
  parameter int WAIT_WR = 1,
  parameter int WAIT_RD = 2
) (
  input logic             pclk,
  input logic             preset,
  apb_wait_slave_if.slave bus
);

  localparam logic [3:0] WAIT_WR_L = 4'(WAIT_WR);
  localparam logic [3:0] WAIT_RD_L = 4'(WAIT_RD);
  localparam logic [8:0] DEPTH_L   = 9'(DEPTH);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [3:0] wcnt_load;
  logic       pready_q, pready_d;
  logic       pslverr_q, pslverr_d;
  logic [7:0] prdata_q, prdata_d;
  logic [7:0] wr_count_q;
  logic       commit;

  logic [7:0] mem [DEPTH];

  logic [7:0] dec_addr;
  logic       dec_write;
  logic       dec_in_range;
  logic       dec_cnt_rd;
  logic       dec_err;
  logic [7:0] mem_rd;
  logic [7:0] dec_rdata;

  // In IDLE the decode looks at the live bus (zero-wait case); otherwise at the latched SETUP values.
  always_comb begin
    dec_addr     = (state_q == IDLE) ? bus.paddr  : addr_q;
    dec_write    = (state_q == IDLE) ? bus.pwrite : write_q;
    dec_in_range = ({1'b0, dec_addr} < DEPTH_L);
    dec_cnt_rd   = (dec_addr == 8'hFF) && !dec_write;
    dec_err      = !(dec_in_range || dec_cnt_rd);
    mem_rd       = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (dec_addr == 8'(i)) begin
        mem_rd = mem[i];
      end
    end
    if (dec_write) begin
      dec_rdata = prdata_q;
    end else if (dec_err) begin
      dec_rdata = 8'h00;
    end else if (dec_cnt_rd) begin
      dec_rdata = wr_count_q;
    end else begin
      dec_rdata = mem_rd;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    wcnt_d    = wcnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    commit    = 1'b0;
    wcnt_load = bus.pwrite ? WAIT_WR_L : WAIT_RD_L;

    case (state_q)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        if (bus.psel && !bus.penable) begin
          addr_d  = bus.paddr;
          write_d = bus.pwrite;
          if (bus.pwrite) begin
            wdata_d = bus.pwdata;
          end
          wcnt_d  = wcnt_load;
          state_d = ACCESS;
          if (wcnt_load == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = dec_err;
            prdata_d  = dec_rdata;
          end
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          wcnt_d    = 4'd0;
        end else if (!pready_q) begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = dec_err;
            prdata_d  = dec_rdata;
          end
        end else if (bus.penable) begin
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          state_d   = IDLE;
          commit    = write_q && dec_in_range;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q   <= IDLE;
      addr_q    <= 8'h00;
      write_q   <= 1'b0;
      wdata_q   <= 8'h00;
      wcnt_q    <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      wcnt_q    <= wcnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Storage and write counter only move on a legal completion edge.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      wr_count_q <= 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (commit) begin
      wr_count_q <= wr_count_q + 8'd1;
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q == 8'(i)) begin
          mem[i] <= wdata_q;
        end
      end
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed bench for apb_wait_slave: a vector table on the default-parameter
// instance plus hand sequences for abort, wrap, zero-wait and async reset.
module tb_apb_wait_slave;

  logic       pclk;
  logic       preset;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic       sel_dut;
  logic       pready;
  logic       pslverr;
  logic [7:0] prdata;

  int n_checks = 0;
  int n_fail   = 0;

  apb_wait_slave_if bus0 ();
  apb_wait_slave_if bus1 ();

  assign bus0.psel    = sel_dut ? 1'b0 : psel;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus1.psel    = sel_dut ? psel : 1'b0;
  assign bus1.penable = penable;
  assign bus1.pwrite  = pwrite;
  assign bus1.paddr   = paddr;
  assign bus1.pwdata  = pwdata;

  assign pready  = sel_dut ? bus1.pready  : bus0.pready;
  assign pslverr = sel_dut ? bus1.pslverr : bus0.pslverr;
  assign prdata  = sel_dut ? bus1.prdata  : bus0.prdata;

  apb_wait_slave #(.DEPTH(64), .WAIT_WR(1), .WAIT_RD(2)) dut0 (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus0.slave)
  );

  apb_wait_slave #(.DEPTH(64), .WAIT_WR(1), .WAIT_RD(0)) dut1 (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus1.slave)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_waits;
  } vec_t;

  vec_t vecs [14];

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One full transfer: SETUP, ACCESS with wait counting, completion edge.
  task automatic apply_stimulus(input logic wr, input logic [7:0] a, input logic [7:0] d,
                                output logic [7:0] rd, output logic err, output int waits);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr   = ~a;
    pwdata  = ~d;
    waits   = 0;
    while (!pready && waits < 40) begin
      @(posedge pclk); #1;
      waits++;
    end
    rd  = prdata;
    err = pslverr;
    @(posedge pclk); #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic xfer_check(input string name, input logic wr, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] exp_rd,
                            input logic exp_err, input int exp_waits);
    logic [7:0] rd;
    logic       err;
    int         waits;
    apply_stimulus(wr, a, d, rd, err, waits);
    check_output({name, " rdata"}, int'(rd), int'(exp_rd));
    check_output({name, " pslverr"}, int'(err), int'(exp_err));
    check_output({name, " waits"}, waits, exp_waits);
  endtask

  // Start a write on dut0, reset while pready is high, check outputs clear without a clock.
  task automatic reset_mid_write(input string name, input logic [7:0] a, input logic [7:0] d,
                                 input logic exp_err_before);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = a;
    pwdata  = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    check_output({name, " pready before reset"}, int'(pready), 1);
    check_output({name, " pslverr before reset"}, int'(pslverr), int'(exp_err_before));
    #3;
    preset = 1'b0;
    #1;
    check_output({name, " pready in reset"}, int'(pready), 0);
    check_output({name, " pslverr in reset"}, int'(pslverr), 0);
    check_output({name, " prdata in reset"}, int'(prdata), 0);
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
  endtask

  initial begin
    logic [7:0] rd;
    logic       err;
    int         waits;
    int         n_err;

    vecs[0]  = '{1'b0, 8'h05, 8'h00, 8'h00, 1'b0, 2};
    vecs[1]  = '{1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 1};
    vecs[2]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 2};
    vecs[3]  = '{1'b0, 8'hFF, 8'h00, 8'h01, 1'b0, 2};
    vecs[4]  = '{1'b1, 8'h40, 8'h11, 8'h01, 1'b1, 1};
    vecs[5]  = '{1'b1, 8'hFF, 8'h22, 8'h01, 1'b1, 1};
    vecs[6]  = '{1'b0, 8'hFF, 8'h00, 8'h01, 1'b0, 2};
    vecs[7]  = '{1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 2};
    vecs[8]  = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 2};
    vecs[9]  = '{1'b1, 8'h3F, 8'h5C, 8'hA5, 1'b0, 1};
    vecs[10] = '{1'b0, 8'h3F, 8'h00, 8'h5C, 1'b0, 2};
    vecs[11] = '{1'b0, 8'h80, 8'h00, 8'h00, 1'b1, 2};
    vecs[12] = '{1'b0, 8'hFF, 8'h00, 8'h02, 1'b0, 2};
    vecs[13] = '{1'b0, 8'h3E, 8'h00, 8'h00, 1'b0, 2};

    preset  = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    pwdata  = 8'h00;
    sel_dut = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check_output("reset pready", int'(pready), 0);
    check_output("reset pslverr", int'(pslverr), 0);
    check_output("reset prdata", int'(prdata), 0);
    preset = 1'b1;
    @(posedge pclk); #1;

    for (int i = 0; i < 14; i++) begin
      xfer_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
                 vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_waits);
    end

    // Abort: psel dropped in the first wait cycle of a write.
    xfer_check("pre-abort write", 1'b1, 8'h02, 8'h77, 8'h00, 1'b0, 1);
    xfer_check("pre-abort read", 1'b0, 8'h02, 8'h00, 8'h77, 1'b0, 2);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h02;
    pwdata  = 8'h3C;
    @(posedge pclk); #1;
    penable = 1'b1;
    check_output("abort wait pready", int'(pready), 0);
    psel    = 1'b0;
    penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      check_output($sformatf("abort idle%0d pready", i), int'(pready), 0);
    end
    xfer_check("post-abort read", 1'b0, 8'h02, 8'h00, 8'h77, 1'b0, 2);
    xfer_check("post-abort count", 1'b0, 8'hFF, 8'h00, 8'h03, 1'b0, 2);

    // ACCESS strobe without SETUP is ignored.
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 8'h02;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      check_output($sformatf("no-setup%0d pready", i), int'(pready), 0);
    end
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;

    // Zero read-wait instance: 256 writes wrap the counter.
    sel_dut = 1'b1;
    n_err   = 0;
    xfer_check("dut1 first write", 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1);
    for (int i = 1; i < 256; i++) begin
      apply_stimulus(1'b1, 8'(i % 64), 8'(i), rd, err, waits);
      if (err !== 1'b0 || waits != 1) n_err++;
    end
    check_output("wrap write errors", n_err, 0);
    xfer_check("wrap count", 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 0);
    xfer_check("dut1 read 05", 1'b0, 8'h05, 8'h00, 8'hC5, 1'b0, 0);
    xfer_check("dut1 read 40", 1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 0);
    sel_dut = 1'b0;
    @(posedge pclk); #1;

    // Async reset in the middle of transfers.
    xfer_check("pre-reset write", 1'b1, 8'h20, 8'h5A, 8'h03, 1'b0, 1);
    xfer_check("pre-reset read", 1'b0, 8'h20, 8'h00, 8'h5A, 1'b0, 2);
    reset_mid_write("reset legal", 8'h20, 8'h77, 1'b0);
    xfer_check("after reset read", 1'b0, 8'h20, 8'h00, 8'h00, 1'b0, 2);
    xfer_check("after reset count", 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 2);
    xfer_check("seed prdata", 1'b1, 8'h21, 8'h99, 8'h00, 1'b0, 1);
    xfer_check("seed prdata read", 1'b0, 8'h21, 8'h00, 8'h99, 1'b0, 2);
    reset_mid_write("reset error", 8'hFF, 8'h44, 1'b1);
    xfer_check("after reset 21", 1'b0, 8'h21, 8'h00, 8'h00, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_wait_slave.md
Name: apb_wait_slave

Overview:
- APB completer that sits directly downstream of the APB master, on its psel/penable/pwrite/paddr/pwdata bus.
- Provides a byte-wide register file with programmable read and write wait states.
- Flags out-of-range and illegal accesses with pslverr.
- Exposes a read-only write-counter register so the master's read path can be exercised against a live, non-memory source.

Parameters:
DEPTH, 64, number of 8-bit storage locations at addresses 0..DEPTH-1 (legal range 1..255)
WAIT_WR, 1, wait cycles inserted in ACCESS phase of a write (0..15)
WAIT_RD, 2, wait cycles inserted in ACCESS phase of a read (0..15)

Ports:
pclk  input  1  bus clock; all state changes on rising edge
preset  input  1  asynchronous active-low reset
psel  input  1  slave select from master
penable  input  1  ACCESS-phase strobe
pwrite  input  1  1 = write, 0 = read
paddr  input  8  byte address
pwdata  input  8  write data
prdata  output  8  read data, registered
pready  output  1  transfer-complete strobe, registered
pslverr  output  1  error response, valid only while pready=1, registered

Behaviour:
- Reset (preset=0, asynchronous):
  - pready=0, pslverr=0, prdata=8'h00.
  - FSM=IDLE, wait counter=0, write counter=0, all storage locations=0.
  - Applies immediately, including mid-transfer; the in-flight write is not committed.
- FSM states: IDLE, ACCESS.
  - IDLE: on an edge with psel=1, penable=0 (SETUP), latch paddr and pwrite, and latch pwdata if writing.
  - On that same edge, load wcnt = pwrite ? WAIT_WR : WAIT_RD, set pready <= (wcnt_load==0), and go to ACCESS.
  - IDLE with psel=1, penable=1 and no prior SETUP: ignored; pready stays 0.
- ACCESS while pready=0 and psel=1:
  - Each edge decrements wcnt.
  - pready <= (wcnt==1).
  - Total wait cycles seen by master = WAIT_x.
- ACCESS while pready=1, psel=1, penable=1 (completion edge):
  - pready <= 0, pslverr <= 0, go to IDLE.
  - A write to a legal address commits the latched data and increments the write counter (8-bit, wraps 255->0).
- ACCESS with psel dropped before completion: abort; go to IDLE, pready=0, no write, counter unchanged.
- Decode, evaluated when pready is set:
  - Address < DEPTH, read or write: legal.
    - Read: prdata <= mem[addr] on the edge that raises pready.
  - Address 8'hFF, read: legal; prdata <= write counter.
  - Address 8'hFF write, or any other address >= DEPTH: pslverr <= 1 together with pready.
    - No storage change; prdata <= 8'h00 for reads.
- prdata otherwise holds its last value; it changes only when a read completes.
- Latency, zero-wait case: pready is high in the first ACCESS cycle, giving the standard 2-cycle APB transfer. With N waits the transfer takes N+2 cycles.
- Back-to-back transfers: the master returns to SETUP (penable=0) after completion. The IDLE state accepts it on the very next edge, so there are no dead cycles.
- pwdata/paddr changes during ACCESS are ignored; the values latched at SETUP are used.

Test Plan:
1. Reset then read addr 8'h05 with WAIT_RD=2 -> pready low 2 ACCESS cycles, high on 3rd; prdata=8'h00, pslverr=0.
2. Write 8'hA5 to 8'h10 (WAIT_WR=1), then read 8'h10 -> write completes in 3 cycles; read returns 8'hA5; reading 8'hFF returns 8'h01.
3. Write to 8'h40 (=DEPTH) and write to 8'hFF -> each completes with pready=1, pslverr=1; a subsequent read of 8'hFF still returns the prior count; no storage changed.
4. Drop psel in the first wait cycle of a write of 8'h3C to 8'h02 -> pready never rises; read 8'h02 returns the old value; write counter unchanged.
5. 256 legal writes, then read 8'hFF -> 8'h00 (wrap); parameter override WAIT_RD=0 -> read completes in 2 cycles.
6. Assert preset=0 mid-ACCESS of a write -> pready/pslverr/prdata go 0 immediately without a clock; target location reads 8'h00 afterwards.
